debug_frame_sequencer: RTL and testbench

//  Shares the serial debug link (debug_clk domain) between two frame requesters. Round-robin arbitrates,

---
 rtl/debug_frame_sequencer_pkg.sv | 29 ++
 rtl/debug_rr_arbiter2.sv | 28 ++
 rtl/debug_frame_sequencer.sv | 135 +++++++++++++
 tb/tb_debug_frame_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_frame_sequencer_pkg.sv
// Shared debug-link definitions: default frame geometry, serialiser state encoding
// and the round-robin pick used by the link arbiter.
package debug_frame_sequencer_pkg;

    localparam int unsigned FRAME_BITS_DEF = 40;
    localparam int unsigned GAP_CYCLES_DEF = 2;
    localparam int unsigned CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_SHIFT = 2'b10,
        ST_GAP   = 2'b11
    } seq_state_t;

    // Single requester wins outright; on a tie the one not served last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last_grant);
        logic [1:0] pick;
        pick = 2'b00;
        case (valid)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_grant ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/debug_rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational and only offered while
// enabled; the last-served requester is remembered on every accepted grant.
module debug_rr_arbiter2
    import debug_frame_sequencer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    logic       r_last_grant;
    logic [1:0] w_grant;

    assign w_grant = i_enable ? rr_pick(i_valid, r_last_grant) : 2'b00;
    assign o_grant = w_grant;

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last_grant <= 1'b1;
        end else if (w_grant != 2'b00) begin
            r_last_grant <= w_grant[1];
        end
    end

endmodule

// File: rtl/debug_frame_sequencer.sv
// Shares the serial debug link between two requesters: arbitrate, send a start
// strobe, shift the frame out MSB first, then hold an idle gap for receiver re-arm.
//
// state | meaning
// IDLE  | link free, arbiter may grant
// START | data_start strobe cycle
// SHIFT | FRAME_BITS data bits on sout
// GAP   | GAP_CYCLES idle cycles, then frame counted
module debug_frame_sequencer
    import debug_frame_sequencer_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                  i_debug_clk,
    input  logic                  i_reset_n,
    input  logic                  i_req0_valid,
    input  logic [FRAME_BITS-1:0] i_req0_data,
    output logic                  o_req0_ready,
    input  logic                  i_req1_valid,
    input  logic [FRAME_BITS-1:0] i_req1_data,
    output logic                  o_req1_ready,
    output logic                  o_data_start,
    output logic                  o_sout,
    output logic                  o_busy,
    output logic                  o_grant_id,
    output logic [CNT_W-1:0]      o_frames_sent
);

    localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    seq_state_t            r_state;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic                  r_data_start;
    logic                  r_sout;
    logic                  r_busy;
    logic                  r_grant_id;
    logic [CNT_W-1:0]      r_frames_sent;

    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_idle;
    logic [FRAME_BITS-1:0] w_sel_data;

    assign w_idle = (r_state == ST_IDLE);

    debug_rr_arbiter2 u_arb (
        .i_clk     (i_debug_clk),
        .i_reset_n (i_reset_n),
        .i_enable  (w_idle),
        .i_valid   ({i_req1_valid, i_req0_valid}),
        .o_grant   (w_grant)
    );

    assign w_accept   = |w_grant;
    assign w_sel_data = w_grant[1] ? i_req1_data : i_req0_data;

    // Outputs are registered on the transition into each state, so they line up
    // with the state they describe rather than trailing it by a cycle.
    always_ff @(posedge i_debug_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_data_start  <= 1'b0;
            r_sout        <= 1'b0;
            r_busy        <= 1'b0;
            r_grant_id    <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_START;
                        r_data_start <= 1'b1;
                        r_sout       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_grant_id   <= w_grant[1];
                        r_shreg      <= w_sel_data;
                        r_bit_cnt    <= '0;
                    end
                end
                ST_START: begin
                    r_state      <= ST_SHIFT;
                    r_data_start <= 1'b0;
                    r_sout       <= r_shreg[FRAME_BITS-1];
                    r_shreg      <= {r_shreg[FRAME_BITS-2:0], 1'b0};
                    r_bit_cnt    <= BIT_W'(1);
                end
                ST_SHIFT: begin
                    if (r_bit_cnt == BIT_LAST) begin
                        r_state   <= ST_GAP;
                        r_sout    <= 1'b0;
                        r_gap_cnt <= GAP_LOAD;
                    end else begin
                        r_sout    <= r_shreg[FRAME_BITS-1];
                        r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_frames_sent <= r_frames_sent + CNT_W'(1);
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_data_start <= 1'b0;
                    r_sout       <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_req0_ready  = w_grant[0];
    assign o_req1_ready  = w_grant[1];
    assign o_data_start  = r_data_start;
    assign o_sout        = r_sout;
    assign o_busy        = r_busy;
    assign o_grant_id    = r_grant_id;
    assign o_frames_sent = r_frames_sent;

endmodule

// File: tb/tb_debug_frame_sequencer.sv
// Bench for debug_frame_sequencer: a 40-bit link receiver model and a scoreboard of
// expected frames; a second instance with a 2-bit counter exercises counter wrap.
`timescale 1ns/1ps
module tb_debug_frame_sequencer;

    localparam int FB = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          v0, v1;
    logic [FB-1:0] d0, d1;
    logic          r0, r1, ds, so, busy, gid;
    logic [15:0]   fs;
    logic          r0w, r1w, dsw, sow, busyw, gidw;
    logic [1:0]    fsw;

    debug_frame_sequencer #(.FRAME_BITS(40), .GAP_CYCLES(2), .CNT_W(16)) u_dut (
        .i_debug_clk(clk), .i_reset_n(rst_n),
        .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(r0),
        .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(r1),
        .o_data_start(ds), .o_sout(so), .o_busy(busy), .o_grant_id(gid),
        .o_frames_sent(fs)
    );

    debug_frame_sequencer #(.FRAME_BITS(40), .GAP_CYCLES(2), .CNT_W(2)) u_dut_w (
        .i_debug_clk(clk), .i_reset_n(rst_n),
        .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(r0w),
        .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(r1w),
        .o_data_start(dsw), .o_sout(sow), .o_busy(busyw), .o_grant_id(gidw),
        .o_frames_sent(fsw)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_frames = 0;
    logic m_last;

    typedef struct {
        logic [FB-1:0] data;
        logic          gid;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Far-end receiver: arms on data_start, captures the next FB bits MSB first.
    logic          rx_arm, rx_valid, rx_gid, rx_gid_cap;
    int            rx_cnt;
    logic [FB-1:0] rx_sh, rx_data;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_arm <= 1'b0; rx_cnt <= 0; rx_sh <= '0; rx_valid <= 1'b0;
            rx_data <= '0; rx_gid <= 1'b0; rx_gid_cap <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (ds) begin
                rx_arm <= 1'b1; rx_cnt <= 0; rx_gid_cap <= gid;
            end else if (rx_arm) begin
                rx_sh  <= {rx_sh[FB-2:0], so};
                rx_cnt <= rx_cnt + 1;
                if (rx_cnt == FB-1) begin
                    rx_arm   <= 1'b0;
                    rx_valid <= 1'b1;
                    rx_data  <= {rx_sh[FB-2:0], so};
                    rx_gid   <= rx_gid_cap;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ds === 1'b1)  chk("no_overlap", so, 0);
            if (dsw === 1'b1) chk("no_overlap_w", sow, 0);
            if (rx_valid === 1'b1) begin
                rx_frames++;
                chk("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("rx_data", rx_data, e.data);
                    chk("rx_gid", rx_gid, e.gid);
                    chk("gid_w", gidw, e.gid);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic model_winner(input logic a, input logic b, input logic last);
        if (a && b) return !last;
        return b;
    endfunction

    task automatic push_exp(input logic [FB-1:0] data, input logic g);
        exp_t t;
        t.data = data;
        t.gid  = g;
        sbq.push_back(t);
    endtask

    task automatic wait_accept(input logic who, output int acc_cyc);
        bit seen;
        seen = 0;
        acc_cyc = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            #1;
            if ((who ? r1 : r0) === 1'b1) seen = 1;
            else @(negedge clk);
        end
        chk("accept_seen", seen, 1);
        if (seen) begin
            acc_cyc = cyc;
            chk("other_ready_low", who ? r0 : r1, 0);
            chk("ready_w", who ? r1w : r0w, 1);
            chk("frames_at_accept", fs, rx_frames);
            chk("frames_w_at_accept", fsw, rx_frames % 4);
            m_last = who;
        end
    endtask

    task automatic wait_idle(output int idle_cyc);
        bit done;
        done = 0;
        idle_cyc = -1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1;
        end
        chk("idle_reached", done, 1);
        idle_cyc = cyc;
        chk("busy_w_idle", busyw, 0);
        chk("frames_at_idle", fs, rx_frames);
    endtask

    task automatic send_one(input logic who, input logic [FB-1:0] data, output int acc);
        @(negedge clk);
        if (who) begin d1 = data; v1 = 1'b1; end
        else     begin d0 = data; v0 = 1'b1; end
        push_exp(data, who);
        wait_accept(who, acc);
        @(negedge clk);
        if (who) v1 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(negedge clk);
        sbq.delete();
        m_last = 1'b1;
        rx_frames = 0;
        rst_n = 1'b1;
    endtask

    logic [1:0] wrap_exp [5];
    int a0, a1, aprev, t_idle;
    logic w;

    initial begin
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; m_last = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ds", ds, 0);
        chk("rst_sout", so, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gid", gid, 0);
        chk("rst_frames", fs, 0);
        chk("rst_frames_w", fsw, 0);
        chk("rst_ready0", r0, 0);
        rst_n = 1'b1;

        // 1: single frame from req0
        @(negedge clk);
        d0 = 40'hA50FAAAAA9; v0 = 1'b1;
        push_exp(d0, 1'b0);
        wait_accept(1'b0, a0);
        @(negedge clk);
        chk("s1_ready_one_cycle", r0, 0);
        chk("s1_ds_high", ds, 1);
        chk("s1_busy", busy, 1);
        chk("s1_gid", gid, 0);
        v0 = 1'b0;
        @(negedge clk);
        chk("s1_ds_one_cycle", ds, 0);
        chk("s1_first_bit", so, 1);
        wait_idle(t_idle);
        chk("s1_frame_len", t_idle - a0, 44);
        chk("s1_frames", fs, 1);
        chk("s1_rx_count", rx_frames, 1);

        // 2: tie straight after reset
        do_reset();
        d0 = 40'h1; d1 = 40'h2; v0 = 1'b1; v1 = 1'b1;
        push_exp(40'h1, 1'b0);
        wait_accept(1'b0, a0);
        @(negedge clk);
        chk("s2_gid0", gid, 0);
        v0 = 1'b0;
        push_exp(40'h2, 1'b1);
        wait_accept(1'b1, a1);
        chk("s2_spacing", a1 - a0, 44);
        @(negedge clk);
        chk("s2_gid1", gid, 1);
        v1 = 1'b0;
        wait_idle(t_idle);

        // 3: fairness under continuous contention
        d0 = 40'h00_0000_3000; d1 = 40'h00_0000_3100; v0 = 1'b1; v1 = 1'b1;
        aprev = -1;
        for (int i = 0; i < 6; i++) begin
            w = model_winner(v0, v1, m_last);
            push_exp(w ? d1 : d0, w);
            wait_accept(w, a0);
            if (aprev >= 0) chk("s3_spacing", a0 - aprev, 44);
            aprev = a0;
            @(negedge clk);
            chk("s3_gid", gid, logic'(i % 2));
            if (w) d1 = d1 + 40'd1; else d0 = d0 + 40'd1;
        end
        v0 = 1'b0; v1 = 1'b0;
        wait_idle(t_idle);

        // 4: req1 arrives mid-SHIFT and must wait for IDLE
        d0 = 40'hC33C5AA596; v0 = 1'b1;
        push_exp(d0, 1'b0);
        wait_accept(1'b0, a0);
        @(negedge clk);
        v0 = 1'b0;
        repeat (15) @(negedge clk);
        d1 = 40'h1234567890; v1 = 1'b1;
        push_exp(d1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (busy !== 1'b1) break;
            chk("s4_ready_holdoff", r1, 0);
            @(negedge clk);
        end
        wait_accept(1'b1, a1);
        chk("s4_first_idle", a1 - a0, 44);
        @(negedge clk);
        v1 = 1'b0;
        wait_idle(t_idle);

        // 5: reset at bit 20 aborts the frame
        d0 = 40'h7FFFFFFFFF; v0 = 1'b1;
        wait_accept(1'b0, a0);
        @(negedge clk);
        v0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("s5_sout_before", so, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_ds_abort", ds, 0);
        chk("s5_sout_abort", so, 0);
        chk("s5_busy_abort", busy, 0);
        chk("s5_frames_abort", fs, 0);
        sbq.delete();
        m_last = 1'b1;
        rx_frames = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_one(1'b1, 40'hFFFFFFFFFF, a0);
        wait_idle(t_idle);
        chk("s5_frames", fs, 1);
        chk("s5_rx_count", rx_frames, 1);

        // 6: 2-bit counter wrap
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_one(1'b0, 40'h55_0000_0000 + 40'(i), a0);
            wait_idle(t_idle);
            chk("s6_wrap", fsw, wrap_exp[i]);
            chk("s6_full", fs, i + 1);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
